// File: rtl/pe_row_db_pkg.sv
// pe_pkg: default widths, loader state encoding and MAC arithmetic helpers for pe_row_db.
// The saturate/wrap choice is made by the caller (PE_ROW_SAT_EN in pe_cell).
package pe_pkg;

    localparam int DEF_INPUT_DATA_WIDTH  = 8;
    localparam int DEF_WEIGHT_DATA_WIDTH = 8;
    localparam int DEF_OUTPUT_DATA_WIDTH = 20;
    localparam int DEF_NUM_PE            = 16;

    typedef enum logic [1:0] {
        LD_FILL,
        LD_FULL,
        LD_PEND
    } ld_state_e;

    function automatic int prod_width(input int in_w, input int wt_w);
        return in_w + wt_w;
    endfunction

    // Returns the sum clamped to out_w signed bits when sat_en is set; otherwise the
    // sum is returned untouched and the caller's out_w-bit truncation wraps it.
    function automatic logic signed [63:0] reduce_sum(input logic signed [63:0] sum,
                                                      input int out_w,
                                                      input logic sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sat_en && (sum > hi)) return hi;
        if (sat_en && (sum < lo)) return lo;
        return sum;
    endfunction

    function automatic logic sum_clamps(input logic signed [63:0] sum, input int out_w);
        return (sum > ((64'sd1 <<< (out_w - 1)) - 64'sd1)) || (sum < -(64'sd1 <<< (out_w - 1)));
    endfunction

endpackage

// File: rtl/pe_row_db_if.sv
// pe_row_db_if: weight-load, swap, feature and partial-sum signals of one systolic row.
// sat_flag exists only when PE_ROW_SAT_EN is defined.
interface pe_row_db_if #(
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int WEIGHT_DATA_WIDTH = 8,
    parameter int OUTPUT_DATA_WIDTH = 20,
    parameter int NUM_PE            = 16
);
    logic                                    w_valid;
    logic signed [WEIGHT_DATA_WIDTH-1:0]     w_data;
    logic                                    w_ready;
    logic                                    w_swap;
    logic                                    swap_err;
    logic                                    in_valid;
    logic signed [INPUT_DATA_WIDTH-1:0]      in_a;
    logic                                    in_ready;
    logic [NUM_PE*OUTPUT_DATA_WIDTH-1:0]     in_b;
    logic signed [INPUT_DATA_WIDTH-1:0]      out_a;
    logic [NUM_PE*OUTPUT_DATA_WIDTH-1:0]     out_b;
    logic [NUM_PE-1:0]                       out_valid;
`ifdef PE_ROW_SAT_EN
    logic                                    sat_flag;
`endif

    modport master (
`ifdef PE_ROW_SAT_EN
        input  sat_flag,
`endif
        output w_valid, w_data, w_swap, in_valid, in_a, in_b,
        input  w_ready, swap_err, in_ready, out_a, out_b, out_valid
    );

    modport slave (
`ifdef PE_ROW_SAT_EN
        output sat_flag,
`endif
        input  w_valid, w_data, w_swap, in_valid, in_a, in_b,
        output w_ready, swap_err, in_ready, out_a, out_b, out_valid
    );
endinterface

// File: rtl/pe_row_db_cell.sv
// pe_cell: one weight-stationary MAC; the weight is supplied by the row's active bank.
// PE_ROW_SAT_EN selects saturating sums and adds the o_clamp output.
module pe_cell
    import pe_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = DEF_INPUT_DATA_WIDTH,
    parameter int WEIGHT_DATA_WIDTH = DEF_WEIGHT_DATA_WIDTH,
    parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic signed [WEIGHT_DATA_WIDTH-1:0] i_weight,
    input  logic signed [INPUT_DATA_WIDTH-1:0]  i_a,
    input  logic signed [OUTPUT_DATA_WIDTH-1:0] i_b,
    input  logic                                i_en,
    output logic signed [INPUT_DATA_WIDTH-1:0]  o_a,
    output logic signed [OUTPUT_DATA_WIDTH-1:0] o_b,
    output logic                                o_en
`ifdef PE_ROW_SAT_EN
    ,
    output logic                                o_clamp
`endif
);
    localparam int PW = prod_width(INPUT_DATA_WIDTH, WEIGHT_DATA_WIDTH);
    localparam int SW = OUTPUT_DATA_WIDTH + 1;
`ifdef PE_ROW_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic signed [PW-1:0]                w_prod;
    logic signed [SW-1:0]                w_sum;
    logic signed [63:0]                  w_sum_wide;
    logic signed [OUTPUT_DATA_WIDTH-1:0] w_res;

    assign w_prod     = PW'(i_a) * PW'(i_weight);
    assign w_sum      = SW'(w_prod) + SW'(i_b);
    assign w_sum_wide = 64'(w_sum);
    assign w_res      = OUTPUT_DATA_WIDTH'(reduce_sum(w_sum_wide, OUTPUT_DATA_WIDTH, SAT_EN));
`ifdef PE_ROW_SAT_EN
    assign o_clamp    = i_en && sum_clamps(w_sum_wide, OUTPUT_DATA_WIDTH);
`endif

    // NOTE: non-blocking assignments here so every cell samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_a  <= '0;
            o_b  <= '0;
            o_en <= 1'b0;
        end else begin
            o_a  <= i_a;
            o_en <= i_en;
            if (i_en) o_b <= w_res;
        end
    end
endmodule

// File: rtl/pe_row_db.sv
// pe_row_db: systolic row of NUM_PE MAC cells with shadow/active weight banks and a drain-safe swap.
// Define PE_ROW_SAT_EN for saturating partial sums and the sticky sat_flag output.
module pe_row_db
    import pe_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = DEF_INPUT_DATA_WIDTH,
    parameter int WEIGHT_DATA_WIDTH = DEF_WEIGHT_DATA_WIDTH,
    parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
    parameter int NUM_PE            = DEF_NUM_PE
) (
    input  logic        clk,
    input  logic        rstn,
    pe_row_db_if.slave  bus
);
    localparam int              CW      = $clog2(NUM_PE + 1);
    localparam int              IXW     = $clog2(NUM_PE);
    localparam logic [CW-1:0]   LAST_IX = CW'(NUM_PE - 1);

    ld_state_e                             r_state;
    logic [CW-1:0]                         r_wcnt;
    logic                                  r_act_valid;
    logic                                  r_swap_err;
    logic signed [WEIGHT_DATA_WIDTH-1:0]   r_shadow [NUM_PE];
    logic signed [WEIGHT_DATA_WIDTH-1:0]   r_active [NUM_PE];

    logic signed [INPUT_DATA_WIDTH-1:0]    w_a [NUM_PE+1];
    logic signed [OUTPUT_DATA_WIDTH-1:0]   w_b [NUM_PE];
    logic [NUM_PE:0]                       w_en;
    logic [NUM_PE-1:0]                     w_out_valid;

    assign bus.w_ready  = (r_state == LD_FILL);
    assign bus.in_ready = r_act_valid && (r_state != LD_PEND);
    assign bus.swap_err = r_swap_err;

    // A feature offered while in_ready is low stays with upstream.
    assign w_en[0]       = bus.in_valid && bus.in_ready;
    assign w_a[0]        = bus.in_a;
    assign w_out_valid   = w_en[NUM_PE:1];
    assign bus.out_valid = w_out_valid;
    assign bus.out_a     = w_a[NUM_PE];

    // NOTE: the weight banks are small register arrays, so they take the reset like any other state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= LD_FILL;
            r_wcnt      <= '0;
            r_act_valid <= 1'b0;
            r_swap_err  <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            unique case (r_state)
                LD_FILL: begin
                    if (bus.w_valid) begin
                        r_shadow[r_wcnt[IXW-1:0]] <= bus.w_data;
                        r_wcnt                    <= r_wcnt + CW'(1);
                        if (r_wcnt == LAST_IX) r_state <= LD_FULL;
                    end
                    if (bus.w_swap) r_swap_err <= 1'b1;
                end
                LD_FULL: begin
                    if (bus.w_swap) r_state <= LD_PEND;
                end
                LD_PEND: begin
                    // Commit only once no cell is still working on the old weight set.
                    if (w_out_valid == '0) begin
                        r_active    <= r_shadow;
                        r_act_valid <= 1'b1;
                        r_wcnt      <= '0;
                        r_state     <= LD_FILL;
                    end
                end
                default: r_state <= LD_FILL;
            endcase
        end
    end

`ifdef PE_ROW_SAT_EN
    logic [NUM_PE-1:0] w_clamp;
    logic              r_sat_flag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          r_sat_flag <= 1'b0;
        else if (|w_clamp)  r_sat_flag <= 1'b1;
    end
    assign bus.sat_flag = r_sat_flag;
`endif

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        pe_cell #(
            .INPUT_DATA_WIDTH  (INPUT_DATA_WIDTH),
            .WEIGHT_DATA_WIDTH (WEIGHT_DATA_WIDTH),
            .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH)
        ) u_cell (
            .clk      (clk),
            .rstn     (rstn),
            .i_weight (r_active[k]),
            .i_a      (w_a[k]),
            .i_b      (bus.in_b[k*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]),
            .i_en     (w_en[k]),
            .o_a      (w_a[k+1]),
            .o_b      (w_b[k]),
            .o_en     (w_en[k+1])
`ifdef PE_ROW_SAT_EN
            ,
            .o_clamp  (w_clamp[k])
`endif
        );
        assign bus.out_b[k*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = w_b[k];
    end
endmodule

// File: tb/tb_pe_row_db.sv
// tb_pe_row_db: directed and randomized stimulus for pe_row_db (NUM_PE=4) against a cycle-indexed model.
// Expected overflow results follow PE_ROW_SAT_EN when it is defined.
module tb_pe_row_db;
    localparam int IW   = 8;
    localparam int WW   = 8;
    localparam int OW   = 20;
    localparam int N    = 4;
    localparam int MAXC = 4096;
    localparam longint MAXV = 2**(OW-1) - 1;
    localparam longint MINV = -(2**(OW-1));

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pe_row_db_if #(.INPUT_DATA_WIDTH(IW), .WEIGHT_DATA_WIDTH(WW),
                   .OUTPUT_DATA_WIDTH(OW), .NUM_PE(N)) bus ();

    pe_row_db #(.INPUT_DATA_WIDTH(IW), .WEIGHT_DATA_WIDTH(WW),
                .OUTPUT_DATA_WIDTH(OW), .NUM_PE(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: loader state as plain counters, pipeline as a history of accepted features.
    int     c  = 0;
    int     c0 = 1;
    int     m_cnt;
    bit     m_pend, m_act, m_err, m_sat;
    longint m_shadow [N];
    longint m_active [N];
    longint exp_b    [N];
    bit     acc_h    [MAXC];
    longint a_h      [MAXC];
    longint w_h      [MAXC][N];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, c, got, exp);
        end
    endtask

    function automatic bit hist_acc(input int i);
        if (i < c0) return 1'b0;
        return acc_h[i];
    endfunction

    function automatic longint reduce(input longint s);
        logic [63:0]          u;
        logic signed [OW-1:0] t;
`ifdef PE_ROW_SAT_EN
        if (s > MAXV) begin m_sat = 1'b1; return MAXV; end
        if (s < MINV) begin m_sat = 1'b1; return MINV; end
`endif
        u = s;
        t = u[OW-1:0];
        return t;
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_pend = 0; m_act = 0; m_err = 0; m_sat = 0;
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = 0; m_active[k] = 0; exp_b[k] = 0;
        end
        c0 = c + 1;
    endfunction

    function automatic void model_edge(input bit wv, input logic signed [WW-1:0] wd, input bit sw,
                                       input bit iv, input logic signed [IW-1:0] a,
                                       input logic [N*OW-1:0] b);
        bit                   empty;
        logic signed [OW-1:0] bs;
        longint               s;
        c++;
        acc_h[c] = iv && m_act && !m_pend;
        a_h[c]   = a;
        for (int k = 0; k < N; k++) w_h[c][k] = m_active[k];
        empty = 1'b1;
        for (int k = 0; k < N; k++) if (hist_acc(c - 1 - k)) empty = 1'b0;
        if (m_pend) begin
            if (empty) begin
                m_active = m_shadow; m_act = 1; m_cnt = 0; m_pend = 0;
            end
        end else if (m_cnt < N) begin
            if (wv) begin m_shadow[m_cnt] = wd; m_cnt++; end
            if (sw) m_err = 1;
        end else if (sw) begin
            m_pend = 1;
        end
        for (int k = 0; k < N; k++) begin
            if (hist_acc(c - k)) begin
                bs = b[k*OW +: OW];
                s  = longint'(bs) + a_h[c-k] * w_h[c-k][k];
                exp_b[k] = reduce(s);
            end
        end
    endfunction

    function automatic longint get_b(input int k);
        logic signed [OW-1:0] v;
        v = bus.out_b[k*OW +: OW];
        return v;
    endfunction

    task automatic compare_all();
        logic [N-1:0] ev;
        for (int k = 0; k < N; k++) ev[k] = hist_acc(c - k);
        check("w_ready",   bus.w_ready,  (!m_pend && m_cnt < N));
        check("in_ready",  bus.in_ready, (m_act && !m_pend));
        check("swap_err",  bus.swap_err, m_err);
        check("out_valid", bus.out_valid, ev);
        check("out_a",     bus.out_a, (c - N + 1 >= c0) ? a_h[c-N+1] : 0);
        for (int k = 0; k < N; k++) check($sformatf("out_b[%0d]", k), get_b(k), exp_b[k]);
`ifdef PE_ROW_SAT_EN
        check("sat_flag",  bus.sat_flag, m_sat);
`endif
    endtask

    function automatic logic [N*OW-1:0] fill_b(input longint v);
        logic [N*OW-1:0] b;
        for (int k = 0; k < N; k++) b[k*OW +: OW] = OW'(v);
        return b;
    endfunction

    function automatic logic [N*OW-1:0] rand_b();
        logic [N*OW-1:0] b;
        for (int k = 0; k < N; k++) b[k*OW +: OW] = OW'($urandom);
        return b;
    endfunction

    task automatic step(input bit wv, input logic signed [WW-1:0] wd, input bit sw,
                        input bit iv, input logic signed [IW-1:0] a, input logic [N*OW-1:0] b);
        bus.w_valid = wv; bus.w_data = wd; bus.w_swap = sw;
        bus.in_valid = iv; bus.in_a = a; bus.in_b = b;
        @(posedge clk);
        model_edge(wv, wd, sw, iv, a, b);
        #1 compare_all();
    endtask

    task automatic idle(input int n, input longint bv);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, fill_b(bv));
    endtask

    task automatic load_all(input logic signed [WW-1:0] w);
        for (int k = 0; k < N; k++) step(1, w, 0, 0, '0, fill_b(0));
    endtask

    task automatic swap_and_wait();
        step(0, '0, 1, 0, '0, fill_b(0));
        for (int i = 0; i < 40 && !bus.in_ready; i++) idle(1, 0);
        check("in_ready_after_swap", bus.in_ready, 1);
    endtask

    task automatic check_cells(input string tag, input longint v);
        for (int k = 0; k < N; k++) check($sformatf("%s[%0d]", tag, k), get_b(k), v);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic stream_with_swap(input logic signed [WW-1:0] w);
        for (int i = 1; i <= 5; i++) step(i <= N, w, i == 5, 1, IW'(i), fill_b(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", c);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit took;
        bus.w_valid = 0; bus.w_data = '0; bus.w_swap = 0;
        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0;
        model_reset();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk) rstn = 1'b1;
        idle(3, 0);

        // weights 1..4, one feature a=5 with in_b=10 walking down the row
        for (int k = 0; k < N; k++) step(1, WW'(k + 1), 0, 0, '0, fill_b(0));
        swap_and_wait();
        step(0, '0, 0, 1, 5, fill_b(10));
        check("walk0", bus.out_valid, 1);
        check("cell0", get_b(0), 15);
        for (int i = 1; i < N; i++) begin
            idle(1, 10);
            check("walk", bus.out_valid, 64'(1) << i);
            check($sformatf("cell%0d", i), get_b(i), 10 + 5 * (i + 1));
        end
        idle(2, 10);

        // next set of 2s streamed in while features flow; swap mid-stream
        stream_with_swap(2);
        check("in_ready_pend", bus.in_ready, 0);
        took = 0;
        for (int j = 0; j < 40 && !took; j++) begin
            took = bus.in_ready;
            step(0, '0, 0, 1, 6, fill_b(0));
        end
        check("held_feature_taken", took, 1);
        idle(N, 0);
        check_cells("new_set", 12);

        // early swap after 3 of 4 words
        for (int k = 0; k < 3; k++) step(1, 7, 0, 0, '0, fill_b(0));
        step(0, '0, 1, 0, '0, fill_b(0));
        check("swap_err_set", bus.swap_err, 1);
        idle(3, 0);
        check("swap_err_sticky", bus.swap_err, 1);
        step(0, '0, 0, 1, 1, fill_b(0));
        idle(N, 0);
        check_cells("active_kept", 2);
        step(1, 7, 1, 0, '0, fill_b(0));
        check("last_word_swap_wready", bus.w_ready, 0);
        check("last_word_swap_inready", bus.in_ready, 1);
        swap_and_wait();
        step(0, '0, 0, 1, 1, fill_b(0));
        idle(N, 0);
        check_cells("sevens", 7);

        // overflow corner
        load_all(-128);
        swap_and_wait();
        step(0, '0, 0, 1, -128, fill_b(MAXV));
        idle(N, MAXV);
`ifdef PE_ROW_SAT_EN
        check_cells("ovf", 524287);
        check("sat_flag_set", bus.sat_flag, 1);
`else
        check_cells("ovf", -507905);
`endif

        // reset while a swap is pending
        stream_with_swap(3);
        check("pend_before_reset", bus.in_ready, 0);
        do_reset();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_w_ready", bus.w_ready, 1);
        check("rst_swap_err", bus.swap_err, 0);
        check("rst_out_b0", get_b(0), 0);
        idle(6, 0);
        check("pend_lost", bus.in_ready, 0);

        // randomized traffic
        load_all(WW'($urandom));
        swap_and_wait();
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 1) == 1, WW'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, IW'($urandom), rand_b());
        idle(N + 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
